vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_sync_gen.sv | 68 ++++++
 tb/tb_vga_sync_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 1440x900 raster timing constants and the 2-bit region encoding.
// The game/renderer block decodes line_state with this same encoding.
package vga_timing_pkg;

    localparam int H_SYNC   = 152;
    localparam int H_BACK   = 232;
    localparam int H_ACTIVE = 1440;
    localparam int H_FRONT  = 80;
    localparam int V_SYNC   = 6;
    localparam int V_BACK   = 25;
    localparam int V_ACTIVE = 900;
    localparam int V_FRONT  = 3;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;  // 1904
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;  // 934

    // Counter origin is the start of sync, so active begins after sync+back porch
    localparam int H_ACT_START = H_SYNC + H_BACK;                   // 384
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE - 1;        // 1823
    localparam int V_ACT_START = V_SYNC + V_BACK;                   // 31
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE - 1;        // 930

    localparam logic H_SYNC_POL = 1'b0;
    localparam logic V_SYNC_POL = 1'b1;

    typedef enum logic [1:0] {
        RGN_SYNC   = 2'b00,
        RGN_BACK   = 2'b01,
        RGN_ACTIVE = 2'b10,
        RGN_FRONT  = 2'b11
    } region_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping 12-bit position counter plus the four-region
// FSM (sync/back/active/front) and the registered sync level. Region changes
// are keyed off the next count value so state and count stay aligned.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   SYNC_W   = H_SYNC,
    parameter int   BACK_W   = H_BACK,
    parameter int   ACTIVE_W = H_ACTIVE,
    parameter int   FRONT_W  = H_FRONT,
    parameter logic POL      = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [11:0] count,
    output region_t     state_nxt,
    output logic        sync,
    output logic        wrap
);

    localparam logic [11:0] LAST        = 12'(SYNC_W + BACK_W + ACTIVE_W + FRONT_W - 1);
    localparam logic [11:0] BACK_START  = 12'(SYNC_W);
    localparam logic [11:0] ACT_START   = 12'(SYNC_W + BACK_W);
    localparam logic [11:0] FRONT_START = 12'(SYNC_W + BACK_W + ACTIVE_W);

    region_t     state;
    logic        at_end;
    logic [11:0] count_nxt;

    // Next count and next region; out-of-range counts are treated as the end so they reload 0
    always_comb begin
        at_end    = (count >= LAST);
        wrap      = inc && at_end;
        count_nxt = at_end ? 12'd0 : count + 12'd1;
        state_nxt = state;
        if (inc) begin
            if (count_nxt == 12'd0)             state_nxt = RGN_SYNC;
            else if (count_nxt == BACK_START)   state_nxt = RGN_BACK;
            else if (count_nxt == ACT_START)    state_nxt = RGN_ACTIVE;
            else if (count_nxt == FRONT_START)  state_nxt = RGN_FRONT;
        end
    end

    // Count, region and sync level advance together on each increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 12'd0;
            state <= RGN_SYNC;
            sync  <= POL;
        end else if (inc) begin
            count <= count_nxt;
            state <= state_nxt;
            sync  <= (state_nxt == RGN_SYNC) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: horizontal/vertical counters, region flags,
// VGA sync pulses and a frame-start strobe for the downstream game block.
module vga_sync_gen #(
    parameter int   H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK     = vga_timing_pkg::H_BACK,
    parameter int   H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int   V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK     = vga_timing_pkg::V_BACK,
    parameter int   V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter logic H_SYNC_POL = vga_timing_pkg::H_SYNC_POL,
    parameter logic V_SYNC_POL = vga_timing_pkg::V_SYNC_POL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic [11:0] char_count,
    output logic [11:0] line_count,
    output logic        pixel_state,
    output logic [1:0]  line_state,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_start
);
    import vga_timing_pkg::*;

    region_t h_state_nxt;
    region_t v_state_nxt;
    logic    h_wrap;
    logic    v_wrap;
    logic    v_inc;

    // The vertical axis steps once per completed line
    assign v_inc = ce && h_wrap;

    vga_axis_counter #(
        .SYNC_W(H_SYNC), .BACK_W(H_BACK), .ACTIVE_W(H_ACTIVE), .FRONT_W(H_FRONT),
        .POL(H_SYNC_POL)
    ) u_h (
        .clk(clk), .reset(reset), .inc(ce),
        .count(char_count), .state_nxt(h_state_nxt), .sync(VGA_HS), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .SYNC_W(V_SYNC), .BACK_W(V_BACK), .ACTIVE_W(V_ACTIVE), .FRONT_W(V_FRONT),
        .POL(V_SYNC_POL)
    ) u_v (
        .clk(clk), .reset(reset), .inc(v_inc),
        .count(line_count), .state_nxt(v_state_nxt), .sync(VGA_VS), .wrap(v_wrap)
    );

    // Region flags and frame strobe, registered from next-state so they match the counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_state  <= RGN_SYNC;
            pixel_state <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            line_state  <= v_state_nxt;
            pixel_state <= (h_state_nxt == RGN_ACTIVE) && (v_state_nxt == RGN_ACTIVE);
            frame_start <= h_wrap && v_wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance and a shrunken-timing instance
// with inverted sync polarities, both checked against a position-based model.
module tb_vga_sync_gen;

    localparam int DHS = 152, DHB = 232, DHA = 1440, DHF = 80;
    localparam int DVS = 6,   DVB = 25,  DVA = 900,  DVF = 3;
    localparam int DHT = DHS + DHB + DHA + DHF;
    localparam int DVT = DVS + DVB + DVA + DVF;
    localparam int SHS = 3, SHB = 4, SHA = 8, SHF = 2;
    localparam int SVS = 2, SVB = 3, SVA = 5, SVF = 2;
    localparam int SHT = SHS + SHB + SHA + SHF;
    localparam int SVT = SVS + SVB + SVA + SVF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;

    logic [11:0] cc_d, lc_d, cc_s, lc_s;
    logic [1:0]  ls_d, ls_s;
    logic        ps_d, hs_d, vs_d, fs_d, ps_s, hs_s, vs_s, fs_s;
    logic [29:0] obs_d, obs_s;

    int vectors = 0;
    int miscompares = 0;
    // model positions and frame-start expectation
    int mhd = 0, mvd = 0, mfd = 0;
    int mhs = 0, mvs = 0, mfs = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut_d (
        .clk(clk), .reset(reset), .ce(ce),
        .char_count(cc_d), .line_count(lc_d), .pixel_state(ps_d), .line_state(ls_d),
        .VGA_HS(hs_d), .VGA_VS(vs_d), .frame_start(fs_d)
    );

    vga_sync_gen #(
        .H_SYNC(SHS), .H_BACK(SHB), .H_ACTIVE(SHA), .H_FRONT(SHF),
        .V_SYNC(SVS), .V_BACK(SVB), .V_ACTIVE(SVA), .V_FRONT(SVF),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .reset(reset), .ce(ce),
        .char_count(cc_s), .line_count(lc_s), .pixel_state(ps_s), .line_state(ls_s),
        .VGA_HS(hs_s), .VGA_VS(vs_s), .frame_start(fs_s)
    );

    assign obs_d = {cc_d, lc_d, ls_d, ps_d, hs_d, vs_d, fs_d};
    assign obs_s = {cc_s, lc_s, ls_s, ps_s, hs_s, vs_s, fs_s};

    function automatic logic [1:0] rgn(int p, int sw, int bw, int aw);
        if (p < sw)           return 2'd0;
        if (p < sw + bw)      return 2'd1;
        if (p < sw + bw + aw) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [29:0] expv(int h, int v, int f, int hsw, int hbw, int haw,
                                         int vsw, int vbw, int vaw, logic hp, logic vp);
        logic [1:0] hr, vr;
        logic [11:0] h12, v12;
        hr = rgn(h, hsw, hbw, haw);
        vr = rgn(v, vsw, vbw, vaw);
        h12 = h[11:0];
        v12 = v[11:0];
        return {h12, v12, vr, (hr == 2'd2) && (vr == 2'd2),
                (hr == 2'd0) ? hp : ~hp, (vr == 2'd0) ? vp : ~vp, (f != 0)};
    endfunction

    function automatic logic [29:0] exp_d();
        return expv(mhd, mvd, mfd, DHS, DHB, DHA, DVS, DVB, DVA, 1'b0, 1'b1);
    endfunction

    function automatic logic [29:0] exp_s();
        return expv(mhs, mvs, mfs, SHS, SHB, SHA, SVS, SVB, SVA, 1'b1, 1'b0);
    endfunction

    task automatic model_zero();
        mhd = 0; mvd = 0; mfd = 0;
        mhs = 0; mvs = 0; mfs = 0;
    endtask

    // one clock with the given ce; model advances raster position if enabled
    task automatic step(input logic c);
        ce = c;
        @(posedge clk);
        #1;
        if (reset) begin
            model_zero();
        end else if (c) begin
            mfd = (mhd == DHT - 1 && mvd == DVT - 1) ? 1 : 0;
            if (mhd == DHT - 1) begin mhd = 0; mvd = (mvd == DVT - 1) ? 0 : mvd + 1; end
            else mhd++;
            mfs = (mhs == SHT - 1 && mvs == SVT - 1) ? 1 : 0;
            if (mhs == SHT - 1) begin mhs = 0; mvs = (mvs == SVT - 1) ? 0 : mvs + 1; end
            else mhs++;
        end else begin
            mfd = 0;
            mfs = 0;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step(1'b1);
        vectors++;
        if (obs_d !== exp_d()) begin
            miscompares++;
            $display("FAIL reset_full dut=%h exp=%h", obs_d, exp_d());
        end
        vectors++;
        if (obs_s !== exp_s()) begin
            miscompares++;
            $display("FAIL reset_small dut=%h exp=%h", obs_s, exp_s());
        end
        reset = 1'b0;
    endtask

    task automatic test_line();
        int hs_low = 0;
        for (int i = 0; i < DHT + 5; i++) begin
            step(1'b1);
            if (i < DHT && hs_d == 1'b0) hs_low++;
            vectors++;
            if (obs_d !== exp_d()) begin
                miscompares++;
                $display("FAIL line_full i=%0d dut=%h exp=%h", i, obs_d, exp_d());
            end
            vectors++;
            if (obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL line_small i=%0d dut=%h exp=%h", i, obs_s, exp_s());
            end
        end
        vectors++;
        if (hs_low != DHS) begin
            miscompares++;
            $display("FAIL hs_low_count got=%0d exp=%0d", hs_low, DHS);
        end
    endtask

    task automatic test_frame();
        int pix = 0, fsc = 0;
        int fh = -1, fv = -1, lh = -1, lv = -1;
        pulse_reset();
        for (int i = 0; i < SHT * SVT; i++) begin
            step(1'b1);
            if (ps_s) begin
                if (fh < 0) begin fh = mhs; fv = mvs; end
                lh = mhs; lv = mvs;
                pix++;
            end
            if (fs_s) fsc++;
            vectors++;
            if (obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL frame_small i=%0d dut=%h exp=%h", i, obs_s, exp_s());
            end
        end
        vectors++;
        if (pix != SHA * SVA) begin
            miscompares++;
            $display("FAIL pixel_count got=%0d exp=%0d", pix, SHA * SVA);
        end
        vectors++;
        if (fh != SHS + SHB || fv != SVS + SVB || lh != SHS + SHB + SHA - 1 || lv != SVS + SVB + SVA - 1) begin
            miscompares++;
            $display("FAIL pixel_bounds got=(%0d,%0d)-(%0d,%0d) exp=(%0d,%0d)-(%0d,%0d)", fh, fv, lh, lv,
                     SHS + SHB, SVS + SVB, SHS + SHB + SHA - 1, SVS + SVB + SVA - 1);
        end
        vectors++;
        if (fsc != 1) begin
            miscompares++;
            $display("FAIL frame_start_count got=%0d exp=1", fsc);
        end
    endtask

    task automatic test_back_to_back();
        int fsc = 0;
        for (int i = 0; i < 2 * SHT * SVT; i++) begin
            step(1'b1);
            if (fs_s) fsc++;
            vectors++;
            if (obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL b2b_small i=%0d dut=%h exp=%h", i, obs_s, exp_s());
            end
        end
        vectors++;
        if (fsc != 2) begin
            miscompares++;
            $display("FAIL b2b_frame_starts got=%0d exp=2", fsc);
        end
    endtask

    task automatic test_ce_toggle();
        int fsc = 0;
        pulse_reset();
        for (int i = 0; i < 2 * SHT * SVT; i++) begin
            step((i % 2) == 0);
            if (fs_s) fsc++;
            vectors++;
            if (obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL ce_toggle_small i=%0d dut=%h exp=%h", i, obs_s, exp_s());
            end
            vectors++;
            if (obs_d !== exp_d()) begin
                miscompares++;
                $display("FAIL ce_toggle_full i=%0d dut=%h exp=%h", i, obs_d, exp_d());
            end
        end
        vectors++;
        if (fsc != 1) begin
            miscompares++;
            $display("FAIL ce_toggle_frame_starts got=%0d exp=1", fsc);
        end
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)));
            vectors++;
            if (obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL ce_random_small i=%0d dut=%h exp=%h", i, obs_s, exp_s());
            end
            vectors++;
            if (obs_d !== exp_d()) begin
                miscompares++;
                $display("FAIL ce_random_full i=%0d dut=%h exp=%h", i, obs_d, exp_d());
            end
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        repeat (100 + $urandom_range(0, 20)) step(1'b1);
        #3;
        reset = 1'b1;
        #1;
        model_zero();
        vectors++;
        if (obs_d !== exp_d()) begin
            miscompares++;
            $display("FAIL async_reset_full dut=%h exp=%h", obs_d, exp_d());
        end
        vectors++;
        if (obs_s !== exp_s()) begin
            miscompares++;
            $display("FAIL async_reset_small dut=%h exp=%h", obs_s, exp_s());
        end
        step(1'b1);
        reset = 1'b0;
        step(1'b1);
        vectors++;
        if (obs_d !== exp_d() || cc_d !== 12'd1) begin
            miscompares++;
            $display("FAIL reset_release_full dut=%h exp=%h", obs_d, exp_d());
        end
        vectors++;
        if (obs_s !== exp_s() || fs_s !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_small dut=%h exp=%h", obs_s, exp_s());
        end
    endtask

    task automatic test_polarity();
        int hs_hi = 0, hs_bad = 0, vs_lo = 0;
        pulse_reset();
        for (int i = 0; i < SHT * SVT; i++) begin
            if (hs_s) begin
                hs_hi++;
                if (mhs >= SHS) hs_bad++;
            end
            if (!vs_s) vs_lo++;
            step(1'b1);
            vectors++;
            if (obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL polarity_small i=%0d dut=%h exp=%h", i, obs_s, exp_s());
            end
        end
        vectors++;
        if (hs_hi != SHS * SVT || hs_bad != 0) begin
            miscompares++;
            $display("FAIL hs_high_cycles got=%0d (outside sync %0d) exp=%0d", hs_hi, hs_bad, SHS * SVT);
        end
        vectors++;
        if (vs_lo != SVS * SHT) begin
            miscompares++;
            $display("FAIL vs_low_cycles got=%0d exp=%0d", vs_lo, SVS * SHT);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_back_to_back();
        test_ce_toggle();
        test_async_reset();
        test_polarity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
